// File: rtl/cen_mean_sub.sv
// Per-block mean removal for four channels: latches sum>>>LOG2N as the mean,
// then streams N sample sets through a one-deep output register with valid/ready flow control.
module cen_mean_sub #(
    parameter int LOG2N = 10,
    parameter int DW    = 26,
    parameter int SW    = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [SW-1:0] sum1,
    input  logic signed [SW-1:0] sum2,
    input  logic signed [SW-1:0] sum3,
    input  logic signed [SW-1:0] sum4,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] x1_in,
    input  logic signed [DW-1:0] x2_in,
    input  logic signed [DW-1:0] x3_in,
    input  logic signed [DW-1:0] x4_in,
    output logic                 in_ready,
    output logic signed [DW:0]   c1,
    output logic signed [DW:0]   c2,
    output logic signed [DW:0]   c3,
    output logic signed [DW:0]   c4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holding valid keeps its data stable until that edge.

    typedef enum logic [1:0] {IDLE, MEAN, STREAM, DONE} state_t;

    localparam logic [LOG2N:0] N_CNT  = {1'b1, {LOG2N{1'b0}}};
    localparam logic [LOG2N:0] N_LAST = N_CNT - 1'b1;

    state_t              state;
    logic [LOG2N:0]      in_cnt;
    logic [LOG2N:0]      out_cnt;
    logic signed [DW-1:0] mean  [4];
    logic signed [DW:0]   c_q   [4];
    logic signed [SW-1:0] sum_a [4];
    logic signed [DW-1:0] x_a   [4];
    logic signed [DW:0]   diff  [4];
    logic                 acc;
    logic                 cons;

    assign sum_a[0] = sum1;
    assign sum_a[1] = sum2;
    assign sum_a[2] = sum3;
    assign sum_a[3] = sum4;
    assign x_a[0]   = x1_in;
    assign x_a[1]   = x2_in;
    assign x_a[2]   = x3_in;
    assign x_a[3]   = x4_in;

    // Both operands sign-extended by one bit so the difference can never wrap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            diff[k] = {x_a[k][DW-1], x_a[k]} - {mean[k][DW-1], mean[k]};
        end
    end

    assign in_ready  = (state == STREAM) && (in_cnt < N_CNT) && (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign cons      = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;
    assign c1        = c_q[0];
    assign c2        = c_q[1];
    assign c3        = c_q[2];
    assign c4        = c_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                mean[k] <= '0;
                c_q[k]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 4; k++) begin
                            mean[k] <= DW'(sum_a[k] >>> LOG2N);
                        end
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        out_valid <= 1'b0;
                        state     <= MEAN;
                    end
                end
                MEAN: state <= STREAM;
                STREAM: begin
                    if (acc) begin
                        for (int k = 0; k < 4; k++) begin
                            c_q[k] <= diff[k];
                        end
                        in_cnt    <= in_cnt + 1'b1;
                        out_valid <= 1'b1;
                    end else if (cons) begin
                        out_valid <= 1'b0;
                    end
                    if (cons) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == N_LAST) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cen_mean_sub.sv
// Randomized self-checking bench for cen_mean_sub (N=4): a floor-division mean model
// feeds an expected-result queue that is compared on every output consume.
module tb_cen_mean_sub;

    localparam int LOG2N = 2;
    localparam int N     = 4;
    localparam int DW    = 26;
    localparam int SW    = 40;
    localparam int CW    = DW + 1;
    localparam int W     = 4 * CW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [SW-1:0] sum1 = '0, sum2 = '0, sum3 = '0, sum4 = '0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] x1_in = '0, x2_in = '0, x3_in = '0, x4_in = '0;
    logic                 in_ready;
    logic signed [DW:0]   c1, c2, c3, c4;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 busy;
    logic                 done;
    logic [1:0]           state_dbg;

    cen_mean_sub #(.LOG2N(LOG2N), .DW(DW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sum1(sum1), .sum2(sum2), .sum3(sum3), .sum4(sum4),
        .in_valid(in_valid),
        .x1_in(x1_in), .x2_in(x2_in), .x3_in(x3_in), .x4_in(x4_in),
        .in_ready(in_ready),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model
    longint m [4];
    logic [W-1:0] exp_q[$];
    int  mode = 0;
    int  pass_res = 0;
    int  pass_acc = 0;
    int  last_cons_cyc = 0;
    bit  done_seen = 1'b0;
    bit  prev_stall = 1'b0;
    logic signed [DW:0] prev_c [4];
    logic fx_dummy;

    function automatic longint model_mean(input longint s);
        longint q;
        longint full;
        full = longint'(1) << DW;
        q = (s >= 0) ? s / N : -((-s + N - 1) / N);
        q = q % full;
        if (q < 0) q += full;
        if (q >= full / 2) q -= full;
        return q;
    endfunction

    function automatic longint field(input logic [W-1:0] v, input int k);
        logic signed [CW-1:0] f;
        f = v[(3-k)*CW +: CW];
        return longint'(f);
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            logic [W-1:0] e;
            longint ev [4];
            if (prev_stall) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_c1", longint'(c1), longint'(prev_c[0]));
                check("hold_c4", longint'(c4), longint'(prev_c[3]));
            end
            if (out_valid && !out_ready) check("stall_in_ready", longint'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("c1", longint'(c1), field(e, 0));
                    check("c2", longint'(c2), field(e, 1));
                    check("c3", longint'(c3), field(e, 2));
                    check("c4", longint'(c4), field(e, 3));
                end
                if (mode == 0 && pass_res > 0) check("throughput", cyc - last_cons_cyc, 1);
                pass_res++;
                last_cons_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                check("accept_limit", longint'(pass_acc < N), 1);
                pass_acc++;
                ev[0] = longint'(x1_in) - m[0];
                ev[1] = longint'(x2_in) - m[1];
                ev[2] = longint'(x3_in) - m[2];
                ev[3] = longint'(x4_in) - m[3];
                e = {ev[0][CW-1:0], ev[1][CW-1:0], ev[2][CW-1:0], ev[3][CW-1:0]};
                exp_q.push_back(e);
            end
            if (done) begin
                check("done_latency", cyc - last_cons_cyc, 1);
                check("done_results", pass_res, N);
                done_seen = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_c[0] = c1; prev_c[1] = c2; prev_c[2] = c3; prev_c[3] = c4;
        end
    end

    // drivers
    longint fx [4];

    task automatic begin_pass(input longint s1, input longint s2, input longint s3, input longint s4);
        @(posedge clk); #1;
        sum1 = SW'(s1); sum2 = SW'(s2); sum3 = SW'(s3); sum4 = SW'(s4);
        m[0] = model_mean(s1); m[1] = model_mean(s2);
        m[2] = model_mean(s3); m[3] = model_mean(s4);
        pass_res = 0; pass_acc = 0; done_seen = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_step(input int i, input int md, inout int stall_left, inout bit stalled);
        @(posedge clk); #1;
        start = 1'b0;
        if (md == 2) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x1_in = DW'($urandom); x2_in = DW'($urandom);
            x3_in = DW'($urandom); x4_in = DW'($urandom);
        end else begin
            in_valid = 1'b1;
            x1_in = DW'(fx[0]); x2_in = DW'(fx[1]); x3_in = DW'(fx[2]); x4_in = DW'(fx[3]);
            if (md == 1 && !stalled && out_valid) begin
                stall_left = 3;
                stalled = 1'b1;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (md == 3 && i == 2) begin
                start = 1'b1;
                sum1 = 40'sd123456; sum2 = -40'sd999; sum3 = 40'sd77; sum4 = 40'sd5;
            end
        end
    endtask

    task automatic finish_pass(input int md);
        int  stall_left = 0;
        bit  stalled = 1'b0;
        for (int i = 0; i < 300 && !done_seen; i++) drive_step(i, md, stall_left, stalled);
        check("pass_timeout", longint'(done_seen), 1);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", longint'(busy), 0);
        check("pass_results", pass_res, N);
        check("pass_accepts", pass_acc, N);
        check("queue_empty", exp_q.size(), 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_pass(input longint s1, input longint s2, input longint s3, input longint s4,
                           input int md);
        mode = md;
        begin_pass(s1, s2, s3, s4);
        finish_pass(md);
    endtask

    initial begin
        fx_dummy = 1'b0;
        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_c1", longint'(c1), 0);
        @(negedge clk); rst_n = 1'b1;

        fx[0] = 13; fx[1] = 0; fx[2] = -5; fx[3] = 2;
        do_pass(40, -10, 0, 8, 0);
        do_pass(40, -10, 0, 8, 1);
        fx[0] = -(longint'(1) << 25); fx[1] = 1; fx[2] = -1; fx[3] = 0;
        do_pass(4 * ((longint'(1) << 25) - 1), 0, -3, 3, 0);
        fx[0] = 13; fx[1] = 0; fx[2] = -5; fx[3] = 2;
        do_pass(40, -10, 0, 8, 3);

        // reset in the middle of a pass
        mode = 0;
        begin_pass(40, -10, 0, 8);
        begin
            int  sl = 0;
            bit  st = 1'b0;
            for (int i = 0; i < 50 && pass_res < 2; i++) drive_step(i, 0, sl, st);
        end
        check("mid_two_results", pass_res, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_c1", longint'(c1), 0);
        check("arst_c3", longint'(c3), 0);
        check("arst_out_valid", longint'(out_valid), 0);
        check("arst_busy", longint'(busy), 0);
        check("arst_in_ready", longint'(in_ready), 0);
        check("arst_state", longint'(state_dbg), 0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", longint'(busy), 0);
        do_pass(40, -10, 0, 8, 0);

        for (int p = 0; p < 20; p++) begin
            longint rs [4];
            for (int k = 0; k < 4; k++) begin
                logic [63:0] r;
                logic signed [SW-1:0] t;
                r = {$urandom, $urandom};
                t = r[SW-1:0];
                rs[k] = longint'(t);
            end
            do_pass(rs[0], rs[1], rs[2], rs[3], 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
